// File: rtl/link_scheduler_if.sv
// link_scheduler_if: bundle of the request, sender and status signals around
// the shared Arduino digit link scheduler.
//
//   key_valid/key_digit  keypad echo request (one-cycle pulse + digit)
//   sec_start/sec_bcd/   secret-send request: pulse, packed BCD value
//   sec_len              (nibble 0 = least significant) and digit count
//   sec_busy/sec_done    secret accepted / one-cycle completion pulse
//   tx_digit/tx_start    digit and launch pulse towards the digit sender
//   tx_done              completion pulse from the digit sender
//   key_drop/timeout_err sticky error flags, cleared by clr_err
//
// The scheduler uses the slave modport; the requesters, the sender and the
// error logic together form the master side.
interface link_scheduler_if;
    logic        key_valid;
    logic [3:0]  key_digit;
    logic        sec_start;
    logic [31:0] sec_bcd;
    logic [3:0]  sec_len;
    logic        sec_busy;
    logic        sec_done;
    logic [3:0]  tx_digit;
    logic        tx_start;
    logic        tx_done;
    logic        key_drop;
    logic        timeout_err;
    logic        clr_err;

    modport slave (
        input  key_valid, key_digit, sec_start, sec_bcd, sec_len, tx_done, clr_err,
        output sec_busy, sec_done, tx_digit, tx_start, key_drop, timeout_err
    );

    modport master (
        output key_valid, key_digit, sec_start, sec_bcd, sec_len, tx_done, clr_err,
        input  sec_busy, sec_done, tx_digit, tx_start, key_drop, timeout_err
    );
endinterface

// File: rtl/link_scheduler.sv
// link_scheduler: sequences the single Arduino digit sender between keypad
// echo and secret send. Keypresses go through a 2-deep FIFO; a secret is
// latched whole. Requesters are granted round-robin per transaction, digits
// are issued one at a time with a start/done handshake, each digit is
// followed by an idle gap, and a missing done aborts after a timeout.
//
// Ports:
//   hwclk   system clock (12 MHz)
//   resetN  asynchronous active-low reset
//   link    link_scheduler_if.slave (request, sender and status signals)
module link_scheduler #(
    parameter int GAP_CYCLES     = 1200,
    parameter int TIMEOUT_CYCLES = 1200000
) (
    input  logic            hwclk,
    input  logic            resetN,
    link_scheduler_if.slave link
);
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_DONE, GAP} state_t;

    localparam logic [20:0] WAIT_LAST = 21'(TIMEOUT_CYCLES - 1);
    localparam logic [20:0] GAP_LAST  = 21'(GAP_CYCLES - 1);

    function automatic logic [3:0] nibbleAt(input logic [31:0] bcd, input logic [2:0] idx);
        return bcd[{idx, 2'b00} +: 4];
    endfunction

    state_t      state;
    logic [3:0]  fifoMem [2];
    logic        fifoRd;
    logic        fifoWr;
    logic [1:0]  fifoCount;
    logic        keyDrop;
    logic [31:0] secBcd;
    logic [3:0]  secLeft;
    logic        secPending;
    logic        secBusy;
    logic        secDone;
    logic        grantSec;
    logic        favourSec;
    logic [3:0]  txDigit;
    logic        txStart;
    logic        timeoutErr;
    logic [20:0] waitCnt;
    logic [20:0] gapCnt;

    logic        keyPending;
    logic        fifoPop;
    logic        fifoPush;
    logic        secCapture;
    logic [3:0]  lenClamped;
    logic [2:0]  nibIdx;
    logic        timeoutHit;
    logic        leaveWait;
    logic        gapExit;
    logic        moreDigits;

    assign keyPending = (fifoCount != 2'd0);
    // The head is consumed while ISSUE presents it; a pop frees a slot for a
    // same-cycle push even when the FIFO is full.
    assign fifoPop    = (state == ISSUE) && !grantSec;
    assign fifoPush   = link.key_valid && ((fifoCount != 2'd2) || fifoPop);
    assign secCapture = link.sec_start && !secBusy;
    assign lenClamped = (link.sec_len > 4'd8) ? 4'd8 : link.sec_len;
    assign nibIdx     = 3'(secLeft - 4'd1);
    assign timeoutHit = (state == WAIT_DONE) && !link.tx_done && (waitCnt == WAIT_LAST);
    assign leaveWait  = (state == WAIT_DONE) && (link.tx_done || timeoutHit);
    // With no gap configured the digit ends straight out of WAIT_DONE.
    assign gapExit    = ((state == GAP) && (gapCnt == GAP_LAST)) ||
                        (leaveWait && (GAP_CYCLES == 0));
    assign moreDigits = grantSec && (secLeft != 4'd0) && !timeoutHit;

    always_ff @(posedge hwclk) begin
        if (fifoPush) fifoMem[fifoWr] <= link.key_digit;
    end

    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            fifoRd    <= 1'b0;
            fifoWr    <= 1'b0;
            fifoCount <= 2'd0;
            keyDrop   <= 1'b0;
        end else begin
            if (fifoPush) fifoWr <= ~fifoWr;
            if (fifoPop)  fifoRd <= ~fifoRd;
            case ({fifoPush, fifoPop})
                2'b10:   fifoCount <= fifoCount + 2'd1;
                2'b01:   fifoCount <= fifoCount - 2'd1;
                default: fifoCount <= fifoCount;
            endcase
            if (link.key_valid && !fifoPush) keyDrop <= 1'b1;
            else if (link.clr_err)           keyDrop <= 1'b0;
        end
    end

    always_ff @(posedge hwclk or negedge resetN) begin
        if (!resetN) begin
            state      <= IDLE;
            secBcd     <= '0;
            secLeft    <= '0;
            secPending <= 1'b0;
            secBusy    <= 1'b0;
            secDone    <= 1'b0;
            grantSec   <= 1'b0;
            favourSec  <= 1'b0;
            txDigit    <= '0;
            txStart    <= 1'b0;
            timeoutErr <= 1'b0;
            waitCnt    <= '0;
            gapCnt     <= '0;
        end else begin
            txStart <= 1'b0;
            secDone <= 1'b0;

            // A set in the same cycle beats the clear.
            if (timeoutHit)        timeoutErr <= 1'b1;
            else if (link.clr_err) timeoutErr <= 1'b0;

            if (secCapture) begin
                secBcd     <= link.sec_bcd;
                secLeft    <= lenClamped;
                secPending <= 1'b1;
                secBusy    <= 1'b1;
            end

            case (state)
                IDLE: begin
                    if (keyPending && (!secPending || !favourSec)) begin
                        grantSec  <= 1'b0;
                        favourSec <= 1'b1;
                        txDigit   <= fifoMem[fifoRd];
                        txStart   <= 1'b1;
                        waitCnt   <= '0;
                        state     <= ISSUE;
                    end else if (secPending) begin
                        grantSec   <= 1'b1;
                        favourSec  <= 1'b0;
                        secPending <= 1'b0;
                        if (secLeft == 4'd0) begin
                            // Empty secret completes without touching the link.
                            secDone <= 1'b1;
                            secBusy <= 1'b0;
                        end else begin
                            txDigit <= nibbleAt(secBcd, nibIdx);
                            secLeft <= secLeft - 4'd1;
                            txStart <= 1'b1;
                            waitCnt <= '0;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: state <= WAIT_DONE;
                WAIT_DONE: begin
                    if (leaveWait) begin
                        // A timed-out secret abandons its remaining digits.
                        if (timeoutHit) secLeft <= 4'd0;
                        gapCnt <= '0;
                        state  <= GAP;
                    end else begin
                        waitCnt <= waitCnt + 21'd1;
                    end
                end
                GAP: gapCnt <= gapCnt + 21'd1;
                default: state <= IDLE;
            endcase

            if (gapExit) begin
                if (moreDigits) begin
                    txDigit <= nibbleAt(secBcd, nibIdx);
                    secLeft <= secLeft - 4'd1;
                    txStart <= 1'b1;
                    waitCnt <= '0;
                    state   <= ISSUE;
                end else begin
                    state <= IDLE;
                    if (grantSec) begin
                        secDone <= 1'b1;
                        secBusy <= 1'b0;
                    end
                end
            end
        end
    end

    assign link.sec_busy    = secBusy;
    assign link.sec_done    = secDone;
    assign link.tx_digit    = txDigit;
    assign link.tx_start    = txStart;
    assign link.key_drop    = keyDrop;
    assign link.timeout_err = timeoutErr;
endmodule

// File: tb/tb_link_scheduler.sv
// tb_link_scheduler: directed bench for link_scheduler with a short gap and
// timeout so every scenario fits in a few hundred cycles.
module tb_link_scheduler;
    localparam int GAP = 4;
    localparam int TMO = 50;

    logic hwclk = 1'b0;
    logic resetN;
    int   vectors = 0;
    int   misses  = 0;

    always #5 hwclk = ~hwclk;

    link_scheduler_if link();

    link_scheduler #(.GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO)) dut (
        .hwclk (hwclk),
        .resetN(resetN),
        .link  (link)
    );

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge hwclk);
        #1;
    endtask

    task automatic pulseKey(input logic [3:0] d);
        link.key_valid = 1'b1;
        link.key_digit = d;
        tick();
        link.key_valid = 1'b0;
    endtask

    task automatic pulseSec(input logic [31:0] bcd, input logic [3:0] len);
        link.sec_start = 1'b1;
        link.sec_bcd   = bcd;
        link.sec_len   = len;
        tick();
        link.sec_start = 1'b0;
    endtask

    task automatic sendDone();
        link.tx_done = 1'b1;
        tick();
        link.tx_done = 1'b0;
    endtask

    task automatic pulseClr();
        link.clr_err = 1'b1;
        tick();
        link.clr_err = 1'b0;
    endtask

    // Cycles until tx_start or sec_done is seen (0 = already high), -1 if none.
    task automatic waitFor(input int budget, output int n);
        n = 0;
        while (!(link.tx_start || link.sec_done) && n < budget) begin
            tick();
            n++;
        end
        if (!(link.tx_start || link.sec_done)) n = -1;
    endtask

    task automatic test_reset();
        resetN = 1'b0;
        tick();
        tick();
        vectors++; if (link.tx_start !== 1'b0) begin misses++; $display("FAIL reset_tx_start got %0b want 0", link.tx_start); end
        vectors++; if (link.tx_digit !== 4'd0) begin misses++; $display("FAIL reset_tx_digit got %0d want 0", link.tx_digit); end
        vectors++; if (link.sec_busy !== 1'b0) begin misses++; $display("FAIL reset_sec_busy got %0b want 0", link.sec_busy); end
        vectors++; if (link.sec_done !== 1'b0) begin misses++; $display("FAIL reset_sec_done got %0b want 0", link.sec_done); end
        vectors++; if (link.key_drop !== 1'b0) begin misses++; $display("FAIL reset_key_drop got %0b want 0", link.key_drop); end
        vectors++; if (link.timeout_err !== 1'b0) begin misses++; $display("FAIL reset_timeout_err got %0b want 0", link.timeout_err); end
        resetN = 1'b1;
        tick();
    endtask

    task automatic test_key_echo();
        pulseKey(4'd5);
        vectors++; if (link.tx_start !== 1'b0) begin misses++; $display("FAIL key_t1_start got %0b want 0", link.tx_start); end
        tick();
        vectors++; if (link.tx_start !== 1'b1) begin misses++; $display("FAIL key_t2_start got %0b want 1", link.tx_start); end
        vectors++; if (link.tx_digit !== 4'd5) begin misses++; $display("FAIL key_t2_digit got %0d want 5", link.tx_digit); end
        repeat (9) tick();
        vectors++; if (link.tx_digit !== 4'd5) begin misses++; $display("FAIL key_hold_digit got %0d want 5", link.tx_digit); end
        vectors++; if (link.tx_start !== 1'b0) begin misses++; $display("FAIL key_hold_start got %0b want 0", link.tx_start); end
        tick();
        // Done and a new key in the same cycle: the key waits out the gap.
        link.key_valid = 1'b1;
        link.key_digit = 4'd9;
        link.tx_done   = 1'b1;
        tick();
        link.key_valid = 1'b0;
        link.tx_done   = 1'b0;
        repeat (GAP) tick();
        vectors++; if (link.tx_start !== 1'b0) begin misses++; $display("FAIL gap_early_start got %0b want 0", link.tx_start); end
        tick();
        vectors++; if (link.tx_start !== 1'b1) begin misses++; $display("FAIL gap_end_start got %0b want 1", link.tx_start); end
        vectors++; if (link.tx_digit !== 4'd9) begin misses++; $display("FAIL gap_end_digit got %0d want 9", link.tx_digit); end
        repeat (2) tick();
        sendDone();
        repeat (10) tick();
    endtask

    task automatic test_secret();
        logic [3:0] exp [6];
        int n;
        exp = '{4'd5, 4'd5, 4'd5, 4'd1, 4'd1, 4'd6};
        pulseSec(32'h00555116, 4'd6);
        vectors++; if (link.sec_busy !== 1'b1) begin misses++; $display("FAIL sec_busy_t1 got %0b want 1", link.sec_busy); end
        tick();
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                waitFor(20, n);
                vectors++; if (n !== GAP) begin misses++; $display("FAIL sec_gap[%0d] got %0d want %0d", i, n, GAP); end
            end
            vectors++; if (link.tx_start !== 1'b1) begin misses++; $display("FAIL sec_start[%0d] got %0b want 1", i, link.tx_start); end
            vectors++; if (link.tx_digit !== exp[i]) begin misses++; $display("FAIL sec_digit[%0d] got %0d want %0d", i, link.tx_digit, exp[i]); end
            vectors++; if (link.sec_busy !== 1'b1) begin misses++; $display("FAIL sec_busy[%0d] got %0b want 1", i, link.sec_busy); end
            repeat (5) tick();
            sendDone();
        end
        waitFor(20, n);
        vectors++; if (n !== GAP) begin misses++; $display("FAIL sec_done_delay got %0d want %0d", n, GAP); end
        vectors++; if (link.sec_done !== 1'b1) begin misses++; $display("FAIL sec_done got %0b want 1", link.sec_done); end
        vectors++; if (link.sec_busy !== 1'b0) begin misses++; $display("FAIL sec_busy_end got %0b want 0", link.sec_busy); end
        tick();
        vectors++; if (link.sec_done !== 1'b0) begin misses++; $display("FAIL sec_done_width got %0b want 0", link.sec_done); end
        repeat (10) tick();
    endtask

    task automatic test_key_buffer();
        int n;
        pulseSec(32'h8, 4'd1);
        tick();
        vectors++; if (link.tx_digit !== 4'd8) begin misses++; $display("FAIL buf_sec_digit got %0d want 8", link.tx_digit); end
        link.key_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            link.key_digit = 4'(k);
            tick();
        end
        link.key_valid = 1'b0;
        vectors++; if (link.key_drop !== 1'b1) begin misses++; $display("FAIL buf_key_drop got %0b want 1", link.key_drop); end
        repeat (2) tick();
        sendDone();
        waitFor(20, n);
        vectors++; if (link.sec_done !== 1'b1 || n !== GAP) begin misses++; $display("FAIL buf_sec_done got done=%0b n=%0d want done=1 n=%0d", link.sec_done, n, GAP); end
        tick();
        waitFor(5, n);
        vectors++; if (n !== 0 || link.tx_digit !== 4'd1) begin misses++; $display("FAIL buf_first_key got n=%0d digit=%0d want n=0 digit=1", n, link.tx_digit); end
        repeat (2) tick();
        sendDone();
        waitFor(20, n);
        vectors++; if (n !== GAP + 1 || link.tx_digit !== 4'd2) begin misses++; $display("FAIL buf_second_key got n=%0d digit=%0d want n=%0d digit=2", n, link.tx_digit, GAP + 1); end
        repeat (2) tick();
        sendDone();
        waitFor(15, n);
        vectors++; if (n !== -1) begin misses++; $display("FAIL buf_extra_start got n=%0d want -1 (no third key)", n); end
        vectors++; if (link.key_drop !== 1'b1) begin misses++; $display("FAIL buf_drop_sticky got %0b want 1", link.key_drop); end
        pulseClr();
        vectors++; if (link.key_drop !== 1'b0) begin misses++; $display("FAIL buf_drop_clear got %0b want 0", link.key_drop); end
    endtask

    task automatic test_arbitration();
        int n;
        resetN = 1'b0;
        tick();
        resetN = 1'b1;
        tick();
        link.key_valid = 1'b1;
        link.key_digit = 4'd4;
        link.sec_start = 1'b1;
        link.sec_bcd   = 32'h9;
        link.sec_len   = 4'd1;
        tick();
        link.key_valid = 1'b0;
        link.sec_start = 1'b0;
        tick();
        vectors++; if (link.tx_start !== 1'b1 || link.tx_digit !== 4'd4) begin misses++; $display("FAIL arb_key_first got start=%0b digit=%0d want start=1 digit=4", link.tx_start, link.tx_digit); end
        repeat (2) tick();
        sendDone();
        waitFor(20, n);
        vectors++; if (n !== GAP + 1 || link.tx_digit !== 4'd9) begin misses++; $display("FAIL arb_sec_second got n=%0d digit=%0d want n=%0d digit=9", n, link.tx_digit, GAP + 1); end
        repeat (2) tick();
        sendDone();
        waitFor(20, n);
        vectors++; if (link.sec_done !== 1'b1) begin misses++; $display("FAIL arb_sec_done got %0b want 1", link.sec_done); end
        repeat (5) tick();
        // A lone key moves the pointer on to SEC.
        pulseKey(4'd3);
        tick();
        vectors++; if (link.tx_digit !== 4'd3) begin misses++; $display("FAIL arb_lone_key got %0d want 3", link.tx_digit); end
        repeat (2) tick();
        sendDone();
        repeat (10) tick();
        link.key_valid = 1'b1;
        link.key_digit = 4'd6;
        link.sec_start = 1'b1;
        link.sec_bcd   = 32'h2;
        link.sec_len   = 4'd1;
        tick();
        link.key_valid = 1'b0;
        link.sec_start = 1'b0;
        tick();
        vectors++; if (link.tx_start !== 1'b1 || link.tx_digit !== 4'd2) begin misses++; $display("FAIL arb_sec_first got start=%0b digit=%0d want start=1 digit=2", link.tx_start, link.tx_digit); end
        repeat (2) tick();
        sendDone();
        waitFor(20, n);
        vectors++; if (link.sec_done !== 1'b1 || n !== GAP) begin misses++; $display("FAIL arb_sec_first_done got done=%0b n=%0d want done=1 n=%0d", link.sec_done, n, GAP); end
        tick();
        vectors++; if (link.tx_start !== 1'b1 || link.tx_digit !== 4'd6) begin misses++; $display("FAIL arb_key_after got start=%0b digit=%0d want start=1 digit=6", link.tx_start, link.tx_digit); end
        repeat (2) tick();
        sendDone();
        repeat (10) tick();
    endtask

    task automatic test_timeout();
        int n;
        pulseSec(32'h123, 4'd3);
        tick();
        vectors++; if (link.tx_digit !== 4'd1) begin misses++; $display("FAIL tmo_first_digit got %0d want 1", link.tx_digit); end
        repeat (TMO) tick();
        vectors++; if (link.timeout_err !== 1'b0) begin misses++; $display("FAIL tmo_early got %0b want 0", link.timeout_err); end
        tick();
        vectors++; if (link.timeout_err !== 1'b1) begin misses++; $display("FAIL tmo_set got %0b want 1", link.timeout_err); end
        waitFor(30, n);
        vectors++; if (link.sec_done !== 1'b1 || link.tx_start !== 1'b0 || n !== GAP) begin misses++; $display("FAIL tmo_abort got done=%0b start=%0b n=%0d want done=1 start=0 n=%0d", link.sec_done, link.tx_start, n, GAP); end
        vectors++; if (link.sec_busy !== 1'b0) begin misses++; $display("FAIL tmo_busy got %0b want 0", link.sec_busy); end
        pulseClr();
        vectors++; if (link.timeout_err !== 1'b0) begin misses++; $display("FAIL tmo_clear got %0b want 0", link.timeout_err); end
        repeat (5) tick();
    endtask

    task automatic test_clamp();
        int n;
        pulseSec(32'h87654321, 4'd12);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i > 0) begin
                waitFor(20, n);
                vectors++; if (n !== GAP) begin misses++; $display("FAIL clamp_gap[%0d] got %0d want %0d", i, n, GAP); end
            end
            vectors++; if (link.tx_start !== 1'b1 || link.tx_digit !== 4'(8 - i)) begin misses++; $display("FAIL clamp_digit[%0d] got start=%0b digit=%0d want start=1 digit=%0d", i, link.tx_start, link.tx_digit, 8 - i); end
            repeat (2) tick();
            sendDone();
        end
        waitFor(20, n);
        vectors++; if (link.sec_done !== 1'b1 || n !== GAP) begin misses++; $display("FAIL clamp_done got done=%0b n=%0d want done=1 n=%0d", link.sec_done, n, GAP); end
        repeat (5) tick();
    endtask

    task automatic test_reset_mid_secret();
        int seen;
        pulseSec(32'h456, 4'd3);
        tick();
        repeat (2) tick();
        sendDone();
        tick();
        #2 resetN = 1'b0;
        #1;
        vectors++; if (link.sec_busy !== 1'b0) begin misses++; $display("FAIL mid_rst_busy got %0b want 0", link.sec_busy); end
        vectors++; if (link.tx_digit !== 4'd0) begin misses++; $display("FAIL mid_rst_digit got %0d want 0", link.tx_digit); end
        tick();
        tick();
        resetN = 1'b1;
        seen = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (link.sec_done || link.tx_start) seen++;
        end
        vectors++; if (seen !== 0) begin misses++; $display("FAIL mid_rst_activity got %0d events want 0", seen); end
        pulseKey(4'd7);
        tick();
        vectors++; if (link.tx_start !== 1'b1 || link.tx_digit !== 4'd7) begin misses++; $display("FAIL mid_rst_key got start=%0b digit=%0d want start=1 digit=7", link.tx_start, link.tx_digit); end
        repeat (2) tick();
        sendDone();
        repeat (10) tick();
        pulseSec(32'h5, 4'd0);
        vectors++; if (link.sec_busy !== 1'b1) begin misses++; $display("FAIL len0_busy got %0b want 1", link.sec_busy); end
        tick();
        vectors++; if (link.sec_done !== 1'b1 || link.sec_busy !== 1'b0) begin misses++; $display("FAIL len0_done got done=%0b busy=%0b want done=1 busy=0", link.sec_done, link.sec_busy); end
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            if (link.tx_start) seen++;
            tick();
        end
        vectors++; if (seen !== 0) begin misses++; $display("FAIL len0_tx_start got %0d starts want 0", seen); end
    endtask

    initial begin
        resetN         = 1'b0;
        link.key_valid = 1'b0;
        link.key_digit = 4'd0;
        link.sec_start = 1'b0;
        link.sec_bcd   = 32'd0;
        link.sec_len   = 4'd0;
        link.tx_done   = 1'b0;
        link.clr_err   = 1'b0;
        test_reset();
        test_key_echo();
        test_secret();
        test_key_buffer();
        test_arbitration();
        test_timeout();
        test_clamp();
        test_reset_mid_secret();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
        $finish;
    end
endmodule
